// File: rtl/io_word_bridge_if.sv
// io_word_bridge_if: handshake bundle between the pin-side host, the core and
// io_word_bridge. The bridge connects through the slave modport, and the host
// and core connect through the master modport. The sticky error flags exist
// only when IO_BRIDGE_ERR_EN is defined.
interface io_word_bridge_if #(
    parameter int PIN_W  = 11,
    parameter int WORD_W = 64
);
    // host -> input assembler
    logic              in_fifo_wenq;
    logic [PIN_W-1:0]  in_fifo_wdata;
    logic              in_fifo_wfull_n;
    // input word FIFO -> core
    logic              in_word_deq;
    logic [WORD_W-1:0] in_word_rdata;
    logic              in_word_rempty_n;
    // core -> output word FIFO
    logic              out_word_enq;
    logic [WORD_W-1:0] out_word_wdata;
    logic              out_word_wfull_n;
    // serialiser -> host
    logic              out_fifo_deq;
    logic [PIN_W-1:0]  out_fifo_rdata;
    logic              out_fifo_rempty_n;
`ifdef IO_BRIDGE_ERR_EN
    logic              err_ovf;
    logic              err_udf;
`endif

    // bridge side
    modport slave (
        input  in_fifo_wenq,
        input  in_fifo_wdata,
        output in_fifo_wfull_n,
        input  in_word_deq,
        output in_word_rdata,
        output in_word_rempty_n,
        input  out_word_enq,
        input  out_word_wdata,
        output out_word_wfull_n,
        input  out_fifo_deq,
        output out_fifo_rdata,
        output out_fifo_rempty_n
`ifdef IO_BRIDGE_ERR_EN
        ,
        output err_ovf,
        output err_udf
`endif
    );

    // host / core side
    modport master (
        output in_fifo_wenq,
        output in_fifo_wdata,
        input  in_fifo_wfull_n,
        output in_word_deq,
        input  in_word_rdata,
        input  in_word_rempty_n,
        output out_word_enq,
        output out_word_wdata,
        input  out_word_wfull_n,
        output out_fifo_deq,
        input  out_fifo_rdata,
        input  out_fifo_rempty_n
`ifdef IO_BRIDGE_ERR_EN
        ,
        input  err_ovf,
        input  err_udf
`endif
    );
endinterface

// File: rtl/io_word_bridge.sv
// io_word_bridge: bridge between narrow GPIO beats and wide core words.
//  - Input path: PIN_W-bit beats are assembled little-endian into WORD_W-bit
//    words and then queued in a first-word-fall-through FIFO of IN_DEPTH words.
//  - Output path: core words are queued in a FIFO of OUT_DEPTH words. A holding
//    register then serialises each word into PIN_W-bit beats.
//  - clr flushes both paths synchronously. io_rst_n does the same asynchronously.
//  - Define IO_BRIDGE_ERR_EN to add the sticky err_ovf / err_udf flags.
// All full/empty flags are registered, so no input reaches them combinationally.
module io_word_bridge #(
    parameter int PIN_W     = 11,
    parameter int WORD_W    = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic            io_clk,
    input  logic            io_rst_n,
    input  logic            clr,
    io_word_bridge_if.slave bus
);
    localparam int BEATS    = (WORD_W + PIN_W - 1) / PIN_W;
    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEATS_P2 = 1 << BW;
    localparam int IAW      = $clog2(IN_DEPTH);
    localparam int ICW      = IAW + 1;
    localparam int OAW      = $clog2(OUT_DEPTH);
    localparam int OCW      = OAW + 1;

    localparam logic [BW-1:0]  LAST_BEAT_C = BW'(BEATS - 1);
    localparam logic [BW-1:0]  BEAT_ONE_C  = BW'(1'b1);
    localparam logic [ICW-1:0] IN_FULL_C   = ICW'(IN_DEPTH);
    localparam logic [ICW-1:0] IN_ONE_C    = ICW'(1'b1);
    localparam logic [IAW-1:0] IN_PTR1_C   = IAW'(1'b1);
    localparam logic [OCW-1:0] OUT_FULL_C  = OCW'(OUT_DEPTH);
    localparam logic [OCW-1:0] OUT_ONE_C   = OCW'(1'b1);
    localparam logic [OAW-1:0] OUT_PTR1_C  = OAW'(1'b1);

    // ---------------- input assembler + input FIFO ----------------
    logic [WORD_W-1:0] acc_r;
    logic [BW-1:0]     beat_cnt_r;
    logic [WORD_W-1:0] word_s;
    logic              beat_ok_s;
    logic              in_push_s;
    logic              in_pop_s;

    logic [WORD_W-1:0] in_mem_r [IN_DEPTH];
    logic [IAW-1:0]    in_wr_ptr_r;
    logic [IAW-1:0]    in_rd_ptr_r;
    logic [ICW-1:0]    in_cnt_r;
    logic [ICW-1:0]    in_cnt_next_s;
    logic              in_full_n_r;
    logic              in_empty_n_r;

    assign beat_ok_s = bus.in_fifo_wenq & in_full_n_r;
    assign in_push_s = beat_ok_s & (beat_cnt_r == LAST_BEAT_C);
    assign in_pop_s  = bus.in_word_deq & in_empty_n_r;

    // Merge the current beat into the partial word; bits of the last beat beyond WORD_W fall away.
    always_comb begin
        word_s = acc_r;
        for (int i = 0; i < WORD_W; i++) begin
            word_s[i] = (beat_cnt_r == BW'(i / PIN_W)) ? bus.in_fifo_wdata[i % PIN_W] : acc_r[i];
        end
    end

    // Next input FIFO occupancy from the accepted push/pop pair.
    always_comb begin
        in_cnt_next_s = in_cnt_r;
        case ({in_push_s, in_pop_s})
            2'b10:   in_cnt_next_s = in_cnt_r + IN_ONE_C;
            2'b01:   in_cnt_next_s = in_cnt_r - IN_ONE_C;
            default: in_cnt_next_s = in_cnt_r;
        endcase
    end

    // Assembler state: the partial word and the beat index, which wraps after the last beat.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            acc_r      <= '0;
            beat_cnt_r <= '0;
        end else if (clr) begin
            acc_r      <= '0;
            beat_cnt_r <= '0;
        end else if (beat_ok_s) begin
            acc_r      <= word_s;
            beat_cnt_r <= (beat_cnt_r == LAST_BEAT_C) ? '0 : beat_cnt_r + BEAT_ONE_C;
        end else begin
            acc_r      <= acc_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Input FIFO storage; the completed word is written at the same edge as its last beat.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            for (int i = 0; i < IN_DEPTH; i++) in_mem_r[i] <= '0;
        end else if (in_push_s && !clr) begin
            in_mem_r[in_wr_ptr_r] <= word_s;
        end else begin
            in_mem_r <= in_mem_r;
        end
    end

    // Input FIFO pointers, occupancy and registered flags.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            in_wr_ptr_r  <= '0;
            in_rd_ptr_r  <= '0;
            in_cnt_r     <= '0;
            in_full_n_r  <= 1'b1;
            in_empty_n_r <= 1'b0;
        end else if (clr) begin
            in_wr_ptr_r  <= '0;
            in_rd_ptr_r  <= '0;
            in_cnt_r     <= '0;
            in_full_n_r  <= 1'b1;
            in_empty_n_r <= 1'b0;
        end else begin
            in_wr_ptr_r  <= in_push_s ? in_wr_ptr_r + IN_PTR1_C : in_wr_ptr_r;
            in_rd_ptr_r  <= in_pop_s  ? in_rd_ptr_r + IN_PTR1_C : in_rd_ptr_r;
            in_cnt_r     <= in_cnt_next_s;
            in_full_n_r  <= (in_cnt_next_s != IN_FULL_C);
            in_empty_n_r <= (in_cnt_next_s != '0);
        end
    end

    assign bus.in_fifo_wfull_n  = in_full_n_r;
    assign bus.in_word_rempty_n = in_empty_n_r;
    assign bus.in_word_rdata    = in_empty_n_r ? in_mem_r[in_rd_ptr_r] : '0;

    // ---------------- output FIFO + serialiser ----------------
    logic [WORD_W-1:0]      out_mem_r [OUT_DEPTH];
    logic [OAW-1:0]         out_wr_ptr_r;
    logic [OAW-1:0]         out_rd_ptr_r;
    logic [OCW-1:0]         out_cnt_r;
    logic [OCW-1:0]         out_cnt_next_s;
    logic                   out_full_n_r;
    logic                   out_empty_n_r;
    logic                   out_push_s;
    logic                   out_pop_s;

    logic [WORD_W-1:0]      hold_r;
    logic                   hold_valid_r;
    logic [BW-1:0]          beat_idx_r;
    logic                   deq_ok_s;
    logic                   last_deq_s;
    logic                   hold_free_s;
    logic [BEATS*PIN_W-1:0] padded_s;
    logic [PIN_W-1:0]       beats_s [BEATS_P2];

    assign out_push_s  = bus.out_word_enq & out_full_n_r;
    assign deq_ok_s    = bus.out_fifo_deq & hold_valid_r;
    assign last_deq_s  = deq_ok_s & (beat_idx_r == LAST_BEAT_C);
    // The holding register frees up when it is empty or its last beat leaves this cycle,
    // so the next word loads at that same edge and back-to-back words have no bubble.
    assign hold_free_s = ~hold_valid_r | last_deq_s;
    assign out_pop_s   = hold_free_s & out_empty_n_r;

    // Next output FIFO occupancy from the accepted push/pop pair.
    always_comb begin
        out_cnt_next_s = out_cnt_r;
        case ({out_push_s, out_pop_s})
            2'b10:   out_cnt_next_s = out_cnt_r + OUT_ONE_C;
            2'b01:   out_cnt_next_s = out_cnt_r - OUT_ONE_C;
            default: out_cnt_next_s = out_cnt_r;
        endcase
    end

    // Output FIFO storage.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) out_mem_r[i] <= '0;
        end else if (out_push_s && !clr) begin
            out_mem_r[out_wr_ptr_r] <= bus.out_word_wdata;
        end else begin
            out_mem_r <= out_mem_r;
        end
    end

    // Output FIFO pointers, occupancy and registered flags.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            out_wr_ptr_r  <= '0;
            out_rd_ptr_r  <= '0;
            out_cnt_r     <= '0;
            out_full_n_r  <= 1'b1;
            out_empty_n_r <= 1'b0;
        end else if (clr) begin
            out_wr_ptr_r  <= '0;
            out_rd_ptr_r  <= '0;
            out_cnt_r     <= '0;
            out_full_n_r  <= 1'b1;
            out_empty_n_r <= 1'b0;
        end else begin
            out_wr_ptr_r  <= out_push_s ? out_wr_ptr_r + OUT_PTR1_C : out_wr_ptr_r;
            out_rd_ptr_r  <= out_pop_s  ? out_rd_ptr_r + OUT_PTR1_C : out_rd_ptr_r;
            out_cnt_r     <= out_cnt_next_s;
            out_full_n_r  <= (out_cnt_next_s != OUT_FULL_C);
            out_empty_n_r <= (out_cnt_next_s != '0);
        end
    end

    // Serialiser: load the FIFO head when free, otherwise step through the beats of the held word.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            beat_idx_r   <= '0;
        end else if (clr) begin
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            beat_idx_r   <= '0;
        end else if (out_pop_s) begin
            hold_r       <= out_mem_r[out_rd_ptr_r];
            hold_valid_r <= 1'b1;
            beat_idx_r   <= '0;
        end else if (last_deq_s) begin
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            beat_idx_r   <= '0;
        end else if (deq_ok_s) begin
            hold_r       <= hold_r;
            hold_valid_r <= hold_valid_r;
            beat_idx_r   <= beat_idx_r + BEAT_ONE_C;
        end else begin
            hold_r       <= hold_r;
            hold_valid_r <= hold_valid_r;
            beat_idx_r   <= beat_idx_r;
        end
    end

    // Split the held word into zero-padded beats; unused slots of the power-of-two table are zero.
    always_comb begin
        padded_s = '0;
        padded_s[WORD_W-1:0] = hold_r;
        for (int k = 0; k < BEATS_P2; k++) beats_s[k] = '0;
        for (int k = 0; k < BEATS; k++) beats_s[k] = padded_s[k*PIN_W +: PIN_W];
    end

    assign bus.out_word_wfull_n  = out_full_n_r;
    assign bus.out_fifo_rempty_n = hold_valid_r;
    assign bus.out_fifo_rdata    = hold_valid_r ? beats_s[beat_idx_r] : '0;

`ifdef IO_BRIDGE_ERR_EN
    // ---------------- sticky error flags ----------------
    logic err_ovf_r;
    logic err_udf_r;
    logic ovf_evt_s;
    logic udf_evt_s;

    assign ovf_evt_s = (bus.in_fifo_wenq & ~in_full_n_r) | (bus.out_word_enq & ~out_full_n_r);
    assign udf_evt_s = (bus.in_word_deq & ~in_empty_n_r) | (bus.out_fifo_deq & ~hold_valid_r);

    // Latch dropped writes and ignored reads until the next flush or reset.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
        end else if (clr) begin
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
        end else begin
            err_ovf_r <= err_ovf_r | ovf_evt_s;
            err_udf_r <= err_udf_r | udf_evt_s;
        end
    end

    assign bus.err_ovf = err_ovf_r;
    assign bus.err_udf = err_udf_r;
`endif
endmodule
